// File: rtl/ov7670_stream_gen_pkg.sv
// ov7670_pkg: shared FSM states, pattern modes and RGB565 colours for the OV7670 stream emulator.
package ov7670_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_HBLANK, ST_VFRONT} state_e;
  typedef enum logic [1:0] {MODE_BARS, MODE_SOLID, MODE_RAMP, MODE_CHECK} mode_e;
  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;
  // Entry 0 is the leftmost bar.
  localparam logic [7:0][15:0] BAR_TABLE = {C_BLACK, C_BLUE, C_RED, C_MAGENTA, C_GREEN, C_CYAN, C_YELLOW, C_WHITE};
endpackage

// File: rtl/ov7670_stream_gen_pattern.sv
// stream_pattern_gen: registered RGB565 test-pattern pixel for coordinate (x, y).
module stream_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int WIDTH = 176
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  mode,
  input  logic [15:0] solid,
  output logic [15:0] pixel
);
  localparam logic [15:0] W16 = 16'(WIDTH);
  localparam logic [15:0] BW16 = 16'(WIDTH / 8);
  logic [15:0] bar_idx, pix_d, pix_q;
  always_comb begin
    bar_idx = x / BW16;
    pix_d = mode == MODE_BARS  ? (bar_idx > 16'd7 ? BAR_TABLE[7] : BAR_TABLE[bar_idx[2:0]]) :
            mode == MODE_SOLID ? solid :
            mode == MODE_RAMP  ? y * W16 + x :
            (x[3] ^ y[3]) ? C_WHITE : C_BLACK;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_q <= '0;
    else pix_q <= pix_d;
  end
  assign pixel = pix_q;
endmodule

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: OV7670-style RGB565 output emulator (PCLK/VSYNC/HREF/DATA) driven by test patterns.
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int WIDTH = 176,
  parameter int HEIGHT = 144,
  parameter int H_BLANK = 32,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK = 2,
  parameter int V_FRONT = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EN,
  input  logic [1:0]  MODE,
  input  logic [15:0] SOLID_COLOR,
  output logic        PCLK_OUT,
  output logic        VSYNC_OUT,
  output logic        HREF_OUT,
  output logic [7:0]  DATA_OUT,
  output logic        FRAME_DONE
);
  localparam int LINE = 2 * WIDTH + H_BLANK;
  localparam logic [15:0] VS_LAST  = 16'(VSYNC_LINES * LINE - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BACK * LINE - 1);
  localparam logic [15:0] VF_LAST  = 16'(V_FRONT * LINE - 1);
  localparam logic [15:0] ACT_LAST = 16'(2 * WIDTH - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] H16      = 16'(HEIGHT);
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d, x_q, x_d, y_q, y_d, solid_q, solid_d, px_x, px_y, pix;
  logic [1:0] mode_q, mode_d;
  logic [7:0] data_q, data_d;
  logic pclk_q, pclk_d, vsync_q, vsync_d, href_q, href_d, done_q, done_d, start;
  // During HBLANK the generator already works on the first pixel of the next line.
  assign px_x = state_q == ST_HBLANK ? 16'd0 : x_q;
  assign px_y = state_q == ST_HBLANK ? y_q + 16'd1 : y_q;
  stream_pattern_gen #(.WIDTH(WIDTH)) u_pat (
    .clk(CLK), .rst(RESET), .x(px_x), .y(px_y), .mode(mode_q), .solid(solid_q), .pixel(pix)
  );
  // Every update happens on the edge where PCLK falls (pclk_q == 1).
  always_comb begin
    pclk_d = ~pclk_q;
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    mode_d = mode_q;
    solid_d = solid_q;
    vsync_d = vsync_q;
    href_d = href_q;
    data_d = data_q;
    done_d = 1'b0;
    start = 1'b0;
    if (pclk_q) begin
      cnt_d = cnt_q + 16'd1;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          start = EN;
        end
        ST_VSYNC: if (cnt_q == VS_LAST) begin
          state_d = ST_VBACK;
          vsync_d = 1'b0;
          cnt_d = '0;
        end
        ST_VBACK: if (cnt_q == VB_LAST) begin
          state_d = ST_ACTIVE;
          href_d = 1'b1;
          data_d = pix[15:8];
          cnt_d = '0;
        end
        ST_ACTIVE: begin
          if (!cnt_q[0]) begin
            data_d = pix[7:0];
            x_d = x_q + 16'd1;
          end else if (cnt_q == ACT_LAST) begin
            state_d = ST_HBLANK;
            href_d = 1'b0;
            data_d = 8'h00;
            cnt_d = '0;
          end else data_d = pix[15:8];
        end
        ST_HBLANK: if (cnt_q == HB_LAST) begin
          cnt_d = '0;
          x_d = '0;
          y_d = y_q + 16'd1;
          state_d = y_q + 16'd1 < H16 ? ST_ACTIVE : ST_VFRONT;
          href_d = y_q + 16'd1 < H16;
          data_d = y_q + 16'd1 < H16 ? pix[15:8] : 8'h00;
        end
        ST_VFRONT: if (cnt_q == VF_LAST) begin
          done_d = 1'b1;
          cnt_d = '0;
          start = EN;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (start) begin
        state_d = ST_VSYNC;
        vsync_d = 1'b1;
        cnt_d = '0;
        x_d = '0;
        y_d = '0;
        mode_d = MODE;
        solid_d = SOLID_COLOR;
      end
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      mode_q <= '0;
      solid_q <= '0;
      pclk_q <= 1'b0;
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      data_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      mode_q <= mode_d;
      solid_q <= solid_d;
      pclk_q <= pclk_d;
      vsync_q <= vsync_d;
      href_q <= href_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end
  assign PCLK_OUT = pclk_q;
  assign VSYNC_OUT = vsync_q;
  assign HREF_OUT = href_q;
  assign DATA_OUT = data_q;
  assign FRAME_DONE = done_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb_ov7670_stream_gen: scoreboard bench for the OV7670 stream emulator on a reduced frame geometry.
module tb_ov7670_stream_gen;
  localparam int W = 26, H = 4, HB = 4, VS = 3, VB = 2, VF = 2;
  localparam int L = 2 * W + HB;
  localparam int F = (VS + VB + H + VF) * L;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [15:0] solid = 16'h0000;
  logic pclk, vs, href, fd;
  logic [7:0] data;
  ov7670_stream_gen #(.WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
    .CLK(clk), .RESET(rst), .EN(en), .MODE(mode), .SOLID_COLOR(solid),
    .PCLK_OUT(pclk), .VSYNC_OUT(vs), .HREF_OUT(href), .DATA_OUT(data), .FRAME_DONE(fd)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic [7:0] sb [$];
  int cyc = 0, done_cnt = 0, pulses = 0, vs_len = 0, bad_lines = 0, line_len = 0, vs_start = 0;
  int act_cnt = 0, data_nz = 0, last_pulses = 0, last_vs = 0, last_bad = 0, last_gap = 0;
  logic prev_h = 1'b0, prev_v = 1'b0;
  logic [7:0] hi_b = 8'h00;
  logic [15:0] p;
  logic [7:0] cap [W*H];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int m, input int x, input int y, input logic [15:0] s);
    int b;
    b = x / (W / 8);
    if (b > 7) b = 7;
    if (m == 1) return s;
    if (m == 2) return 16'(y * W + x);
    if (m == 3) return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 16'hFFFF : 16'h0000;
    case (b)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push_frame(input int m, input logic [15:0] s);
    logic [15:0] v;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        v = model(m, x, y, s);
        sb.push_back(v[15:8]);
        sb.push_back(v[7:0]);
      end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string nm);
    int n0 = done_cnt;
    int k = 0;
    while (done_cnt == n0 && k < 2 * F + 200) begin
      cycles(1);
      k++;
    end
    chk(nm, done_cnt - n0, 1);
  endtask

  task automatic wait_vs(input string nm);
    int k = 0;
    while (!vs && k < 400) begin
      cycles(1);
      k++;
    end
    chk(nm, int'(vs), 1);
  endtask

  task automatic wait_pulses(input int n, input string nm);
    int k = 0;
    while (pulses < n && k < 2 * F) begin
      cycles(1);
      k++;
    end
    chk(nm, int'(pulses >= n), 1);
  endtask

  // Monitor: one byte sample per PCLK-high cycle, compared against the scoreboard.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      prev_h = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (vs || href || fd || data != 8'h00) act_cnt++;
      if (fd) begin
        done_cnt++;
        last_gap = cyc - vs_start;
        last_pulses = pulses;
        last_vs = vs_len;
        last_bad = bad_lines;
      end
      if (vs && !prev_v) begin
        vs_start = cyc;
        pulses = 0;
        vs_len = 0;
        bad_lines = 0;
      end
      prev_v = vs;
      if (pclk) begin
        if (vs) vs_len++;
        if (!href && data != 8'h00) data_nz++;
        if (href) begin
          if (!prev_h) begin
            pulses++;
            line_len = 0;
          end
          if (line_len % 2 == 0) hi_b = data;
          else if (pulses <= H && line_len < 2 * W) begin
            p = {hi_b, data};
            cap[(pulses - 1) * W + line_len / 2] = {p[15:13], p[10:8], p[4:3]};
          end
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: got %0h with no expected byte queued", data);
          end else chk($sformatf("byte line%0d idx%0d", pulses - 1, line_len), int'(data), int'(sb.pop_front()));
          line_len++;
        end else if (prev_h && line_len != 2 * W) bad_lines++;
        prev_h = href;
      end
    end
  end

  initial begin
    int a0;
    cycles(3);
    chk("reset_outputs", int'({pclk, vs, href, fd, data}), 0);
    rst = 1'b0;
    a0 = act_cnt;
    cycles(200);
    chk("idle_en0_quiet", act_cnt - a0, 0);
    // Frame A: address ramp, single frame
    mode = 2'd2;
    en = 1'b1;
    push_frame(2, 16'h0000);
    wait_vs("A_start");
    en = 1'b0;
    wait_done("A_done");
    chk("A_href_pulses", last_pulses, H);
    chk("A_bad_lines", last_bad, 0);
    chk("A_vsync_len", last_vs, VS * L);
    chk("A_frame_cycles", last_gap, 2 * F);
    a0 = act_cnt;
    cycles(100);
    chk("A_idle_after", act_cnt - a0, 0);
    // Frames B and C: solid colour, change ignored until the next latch
    mode = 2'd1;
    solid = 16'h1234;
    en = 1'b1;
    push_frame(1, 16'h1234);
    wait_vs("B_start");
    wait_pulses(1, "B_line0");
    solid = 16'hABCD;
    push_frame(1, 16'hABCD);
    wait_done("B_done");
    chk("B_href_pulses", last_pulses, H);
    chk("BC_back_to_back_vsync", int'(vs), 1);
    en = 1'b0;
    wait_done("C_done");
    chk("C_href_pulses", last_pulses, H);
    chk("C_sb_drained", sb.size(), 0);
    // Frame D: colour bars, EN dropped during line 2
    mode = 2'd0;
    en = 1'b1;
    push_frame(0, 16'h0000);
    wait_vs("D_start");
    wait_pulses(3, "D_line2");
    en = 1'b0;
    wait_done("D_done");
    chk("D_href_pulses", last_pulses, H);
    chk("D_bad_lines", last_bad, 0);
    a0 = act_cnt;
    cycles(50);
    chk("D_idle_vsync", int'(vs), 0);
    chk("D_idle_quiet", act_cnt - a0, 0);
    // Frame E: checker captured as RGB332
    mode = 2'd3;
    en = 1'b1;
    push_frame(3, 16'h0000);
    wait_vs("E_start");
    en = 1'b0;
    wait_done("E_done");
    chk("E_cap_addr0", int'(cap[0]), 8'h00);
    chk("E_cap_addr8", int'(cap[8]), 8'hFF);
    chk("E_cap_addr16", int'(cap[16]), 8'h00);
    chk("E_cap_y1_x8", int'(cap[W + 8]), 8'hFF);
    // Frame F: asynchronous reset in the middle of an active line
    mode = 2'd2;
    en = 1'b1;
    push_frame(2, 16'h0000);
    wait_vs("F_start");
    en = 1'b0;
    wait_pulses(2, "F_line1");
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("F_async_reset", int'({pclk, vs, href, fd, data}), 0);
    sb.delete();
    cycles(3);
    rst = 1'b0;
    a0 = act_cnt;
    cycles(300);
    chk("F_idle_after_reset", act_cnt - a0, 0);
    chk("data_zero_href_low", data_nz, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
